// File: rtl/wr_port_arbiter_if.sv
// rtl/wr_port_arbiter_if.sv - two-requester AXI write bus plus the shared RAM-side write channel
interface wr_port_arbiter_if #(
    parameter int DW = 512
);
    logic [63:0]     S0_AWADDR,  S1_AWADDR;
    logic [7:0]      S0_AWLEN,   S1_AWLEN;
    logic            S0_AWVALID, S1_AWVALID;
    logic            S0_AWREADY, S1_AWREADY;
    logic [DW-1:0]   S0_WDATA,   S1_WDATA;
    logic            S0_WLAST,   S1_WLAST;
    logic            S0_WVALID,  S1_WVALID;
    logic            S0_WREADY,  S1_WREADY;
    logic [1:0]      S0_BRESP,   S1_BRESP;
    logic            S0_BVALID,  S1_BVALID;
    logic            S0_BREADY,  S1_BREADY;

    logic [63:0]     M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    // Arbiter side: sees requesters and RAM as its peers.
    modport slave (
        input  S0_AWADDR, S1_AWADDR, S0_AWLEN, S1_AWLEN, S0_AWVALID, S1_AWVALID,
        output S0_AWREADY, S1_AWREADY,
        input  S0_WDATA, S1_WDATA, S0_WLAST, S1_WLAST, S0_WVALID, S1_WVALID,
        output S0_WREADY, S1_WREADY,
        output S0_BRESP, S1_BRESP, S0_BVALID, S1_BVALID,
        input  S0_BREADY, S1_BREADY,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    // Environment side: drives the requesters and models the RAM.
    modport master (
        output S0_AWADDR, S1_AWADDR, S0_AWLEN, S1_AWLEN, S0_AWVALID, S1_AWVALID,
        input  S0_AWREADY, S1_AWREADY,
        output S0_WDATA, S1_WDATA, S0_WLAST, S1_WLAST, S0_WVALID, S1_WVALID,
        input  S0_WREADY, S1_WREADY,
        input  S0_BRESP, S1_BRESP, S0_BVALID, S1_BVALID,
        output S0_BREADY, S1_BREADY,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - two-port AXI write arbiter with AW-ordered W and B routing
module wr_port_arbiter #(
    parameter int DW          = 512,
    parameter int ORDER_DEPTH = 16
) (
    input  logic                clk,
    input  logic                sys_reset,
    wr_port_arbiter_if.slave    bus,
    output logic [8:0]          outstanding
);

    localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(ORDER_DEPTH);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t state;
    logic   grant;
    logic   last_grant;

    // Order FIFOs hold one requester id per accepted AW, in AW order.
    logic [ORDER_DEPTH-1:0] w_mem, b_mem;
    logic [PW-1:0]          w_wr, w_rd, b_wr, b_rd;
    logic [CW-1:0]          w_cnt, b_cnt;

    logic aw_hs, w_pop, b_hs;
    logic w_ne, b_ne, w_sel, b_sel;
    logic can_grant;
    logic any_req, both_req;

    assign w_ne      = (w_cnt != '0);
    assign b_ne      = (b_cnt != '0);
    assign w_sel     = w_mem[w_rd];
    assign b_sel     = b_mem[b_rd];
    assign can_grant = (w_cnt != FULL) && (b_cnt != FULL);
    assign any_req   = bus.S0_AWVALID | bus.S1_AWVALID;
    assign both_req  = bus.S0_AWVALID & bus.S1_AWVALID;

    // AW channel follows the granted requester while in ADDR.
    assign bus.M_AXI_AWVALID = (state == ADDR) & (grant ? bus.S1_AWVALID : bus.S0_AWVALID);
    assign bus.M_AXI_AWADDR  = grant ? bus.S1_AWADDR : bus.S0_AWADDR;
    assign bus.M_AXI_AWLEN   = grant ? bus.S1_AWLEN  : bus.S0_AWLEN;
    assign bus.S0_AWREADY    = (state == ADDR) & ~grant & bus.M_AXI_AWREADY;
    assign bus.S1_AWREADY    = (state == ADDR) &  grant & bus.M_AXI_AWREADY;
    assign aw_hs             = bus.M_AXI_AWVALID & bus.M_AXI_AWREADY;

    // W channel: beats of a requester without a queued AW stay blocked.
    assign bus.M_AXI_WVALID  = w_ne & (w_sel ? bus.S1_WVALID : bus.S0_WVALID);
    assign bus.M_AXI_WDATA   = w_sel ? bus.S1_WDATA : bus.S0_WDATA;
    assign bus.M_AXI_WLAST   = w_sel ? bus.S1_WLAST : bus.S0_WLAST;
    assign bus.M_AXI_WSTRB   = '1;
    assign bus.S0_WREADY     = w_ne & ~w_sel & bus.M_AXI_WREADY;
    assign bus.S1_WREADY     = w_ne &  w_sel & bus.M_AXI_WREADY;
    assign w_pop             = bus.M_AXI_WVALID & bus.M_AXI_WREADY & bus.M_AXI_WLAST;

    // B channel: a response with no queued owner is stalled, never dropped.
    assign bus.S0_BVALID     = b_ne & ~b_sel & bus.M_AXI_BVALID;
    assign bus.S1_BVALID     = b_ne &  b_sel & bus.M_AXI_BVALID;
    assign bus.S0_BRESP      = bus.M_AXI_BRESP;
    assign bus.S1_BRESP      = bus.M_AXI_BRESP;
    assign bus.M_AXI_BREADY  = b_ne & (b_sel ? bus.S1_BREADY : bus.S0_BREADY);
    assign b_hs              = bus.M_AXI_BVALID & bus.M_AXI_BREADY;

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && can_grant) begin
                        grant <= both_req ? ~last_grant : bus.S1_AWVALID;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            w_mem <= '0;
            w_wr  <= '0;
            w_rd  <= '0;
            w_cnt <= '0;
        end else begin
            if (aw_hs) begin
                w_mem[w_wr] <= grant;
                w_wr        <= w_wr + PW'(1);
            end
            if (w_pop) begin
                w_rd <= w_rd + PW'(1);
            end
            case ({aw_hs, w_pop})
                2'b10:   w_cnt <= w_cnt + CW'(1);
                2'b01:   w_cnt <= w_cnt - CW'(1);
                default: w_cnt <= w_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            b_mem <= '0;
            b_wr  <= '0;
            b_rd  <= '0;
            b_cnt <= '0;
        end else begin
            if (aw_hs) begin
                b_mem[b_wr] <= grant;
                b_wr        <= b_wr + PW'(1);
            end
            if (b_hs) begin
                b_rd <= b_rd + PW'(1);
            end
            case ({aw_hs, b_hs})
                2'b10:   b_cnt <= b_cnt + CW'(1);
                2'b01:   b_cnt <= b_cnt - CW'(1);
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            outstanding <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 9'd1;
                2'b01:   outstanding <= outstanding - 9'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - randomized scoreboard bench for wr_port_arbiter
module tb_wr_port_arbiter;
    localparam int DW    = 128;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic [8:0] outstanding;
    always #5 clk = ~clk;

    wr_port_arbiter_if #(.DW(DW)) bus ();
    wr_port_arbiter #(.DW(DW), .ORDER_DEPTH(DEPTH)) dut (
        .clk(clk), .sys_reset(sys_reset), .bus(bus), .outstanding(outstanding)
    );

    logic [63:0]   s_awaddr [2];
    logic [7:0]    s_awlen  [2];
    logic          s_awvalid[2], s_wlast[2], s_wvalid[2], s_bready[2];
    logic [DW-1:0] s_wdata  [2];
    logic          s_awready[2], s_wready[2], s_bvalid[2];
    logic [1:0]    s_bresp  [2];
    logic          m_awready, m_wready, m_bvalid;
    logic [1:0]    m_bresp;

    assign bus.S0_AWADDR = s_awaddr[0];   assign bus.S1_AWADDR = s_awaddr[1];
    assign bus.S0_AWLEN = s_awlen[0];     assign bus.S1_AWLEN = s_awlen[1];
    assign bus.S0_AWVALID = s_awvalid[0]; assign bus.S1_AWVALID = s_awvalid[1];
    assign bus.S0_WDATA = s_wdata[0];     assign bus.S1_WDATA = s_wdata[1];
    assign bus.S0_WLAST = s_wlast[0];     assign bus.S1_WLAST = s_wlast[1];
    assign bus.S0_WVALID = s_wvalid[0];   assign bus.S1_WVALID = s_wvalid[1];
    assign bus.S0_BREADY = s_bready[0];   assign bus.S1_BREADY = s_bready[1];
    assign s_awready[0] = bus.S0_AWREADY; assign s_awready[1] = bus.S1_AWREADY;
    assign s_wready[0] = bus.S0_WREADY;   assign s_wready[1] = bus.S1_WREADY;
    assign s_bvalid[0] = bus.S0_BVALID;   assign s_bvalid[1] = bus.S1_BVALID;
    assign s_bresp[0] = bus.S0_BRESP;     assign s_bresp[1] = bus.S1_BRESP;
    assign bus.M_AXI_AWREADY = m_awready;
    assign bus.M_AXI_WREADY  = m_wready;
    assign bus.M_AXI_BVALID  = m_bvalid;
    assign bus.M_AXI_BRESP   = m_bresp;

    typedef struct { int id; int seq; } wo_t;
    typedef struct { int id; logic [1:0] resp; } be_t;

    int          total = 0, bad = 0;
    int          phase = 0, cyc = 0;
    logic [31:0] salt   [2][64];
    int          len_tab[2][64];
    int          next_aw_seq[2];
    wo_t         w_order[$];
    int          done_q[$];
    be_t         exp_b[$];
    int          aw_log[$];
    int          aw_cnt = 0, aw_base = 0, beat = 0, model_out = 0;
    int          b_budget = 1000000;
    int          first_req_cyc = -1, first_m_cyc = -1;
    int          mid, mseq, d_aw, d_b;
    bit          mon_en = 1'b0, ram_fast = 1'b1, b_hs_f = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [63:0] mk_addr(input int id, input int seq);
        logic [31:0] idv;
        idv = 32'(id);
        return {idv[0], 15'(phase), 16'(seq), salt[id][seq]};
    endfunction

    function automatic logic [DW-1:0] mk_data(input int id, input int seq, input int j);
        logic [31:0] w;
        w = salt[id][seq] ^ (32'(j + 1) * 32'h9e37_79b9) ^ 32'(id * 32'h0101_0000);
        return {(DW/32){w}};
    endfunction

    // Reference model: per-requester AW order, data follows AW order, B follows AW order.
    initial forever begin
        @(negedge clk);
        cyc++;
        b_hs_f = m_bvalid && bus.M_AXI_BREADY;
        if (mon_en) begin
            d_aw = 0;
            d_b  = 0;
            if (first_req_cyc < 0 && (s_awvalid[0] || s_awvalid[1])) first_req_cyc = cyc;
            if (first_m_cyc < 0 && bus.M_AXI_AWVALID) first_m_cyc = cyc;
            chk("outstanding", 64'(outstanding), 64'(model_out));
            for (int i = 0; i < 2; i++)
                if (s_wready[i])
                    chk("wready_owner", 64'(w_order.size() > 0 && w_order[0].id == i), 1);
            if (bus.M_AXI_WVALID && m_wready) begin
                if (w_order.size() == 0) begin
                    chk("w_without_aw", 1, 0);
                end else begin
                    chk("w_data", 64'(bus.M_AXI_WDATA[63:0] == mk_data(w_order[0].id, w_order[0].seq, beat)[63:0]
                                     && bus.M_AXI_WDATA == mk_data(w_order[0].id, w_order[0].seq, beat)), 1);
                    chk("w_last", 64'(bus.M_AXI_WLAST), 64'(beat == len_tab[w_order[0].id][w_order[0].seq]));
                    if (beat == len_tab[w_order[0].id][w_order[0].seq]) begin
                        done_q.push_back(w_order[0].id);
                        void'(w_order.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            if (bus.M_AXI_AWVALID && m_awready) begin
                mid  = int'(bus.M_AXI_AWADDR[63]);
                mseq = next_aw_seq[mid];
                if (mseq > 63) begin
                    chk("aw_extra", 64'(mseq), 63);
                end else begin
                    chk("aw_addr", bus.M_AXI_AWADDR, mk_addr(mid, mseq));
                    chk("aw_len", 64'(bus.M_AXI_AWLEN), 64'(len_tab[mid][mseq]));
                    w_order.push_back('{mid, mseq});
                end
                aw_log.push_back(mid);
                next_aw_seq[mid]++;
                aw_cnt++;
                d_aw = 1;
            end
            for (int i = 0; i < 2; i++) begin
                if (s_bvalid[i] && s_bready[i]) begin
                    if (exp_b.size() == 0) begin
                        chk("b_unexpected", 64'(i), 64'hff);
                    end else begin
                        chk("b_owner", 64'(i), 64'(exp_b[0].id));
                        chk("b_resp", 64'(s_bresp[i]), 64'(exp_b[0].resp));
                        void'(exp_b.pop_front());
                    end
                    d_b++;
                end
            end
            if (b_hs_f) chk("b_routed_once", 64'(d_b), 1);
            model_out = model_out + d_aw - (b_hs_f ? 1 : 0);
        end
    end

    // RAM model and requester BREADY.
    initial forever begin
        @(posedge clk);
        #1;
        m_awready   = ram_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        m_wready    = ram_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_bready[0] = ram_fast ? 1'b1 : 1'($urandom_range(0, 1));
        s_bready[1] = ram_fast ? 1'b1 : 1'($urandom_range(0, 1));
        if (m_bvalid && b_hs_f) m_bvalid = 1'b0;
        if (!m_bvalid && done_q.size() > 0 && b_budget > 0) begin
            m_bresp  = 2'($urandom_range(0, 3));
            exp_b.push_back('{done_q.pop_front(), m_bresp});
            m_bvalid = 1'b1;
            b_budget--;
        end
    end

    task automatic run_aw(input int id, input int n, input int gap, input int dly);
        int t;
        repeat (dly) begin @(posedge clk); #1; end
        for (int k = 0; k < n; k++) begin
            s_awaddr[id]  = mk_addr(id, k);
            s_awlen[id]   = 8'(len_tab[id][k]);
            s_awvalid[id] = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_awready[id] && t < 3000);
            if (!s_awready[id]) begin fail("aw_wait"); s_awvalid[id] = 1'b0; return; end
            @(posedge clk); #1;
            s_awvalid[id] = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_w(input int id, input int n, input int gap, input int dly);
        int t;
        repeat (dly) begin @(posedge clk); #1; end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j <= len_tab[id][k]; j++) begin
                s_wdata[id]  = mk_data(id, k, j);
                s_wlast[id]  = (j == len_tab[id][k]);
                s_wvalid[id] = 1'b1;
                t = 0;
                do begin @(negedge clk); t++; end while (!s_wready[id] && t < 3000);
                if (!s_wready[id]) begin fail("w_wait"); s_wvalid[id] = 1'b0; return; end
                @(posedge clk); #1;
                s_wvalid[id] = 1'b0;
                repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic run_phase(input int n0, input int n1, input int gap, input int fixlen,
                             input int a0, input int a1, input int w0, input int w1, input bit fill);
        int t;
        phase++;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) begin
                salt[i][k]    = $urandom;
                len_tab[i][k] = (fixlen >= 0) ? fixlen : int'($urandom_range(0, fill ? 3 : 7));
            end
        next_aw_seq[0] = 0;
        next_aw_seq[1] = 0;
        aw_log.delete();
        first_req_cyc = -1;
        first_m_cyc   = -1;
        aw_base       = aw_cnt;
        b_budget      = fill ? 0 : 1000000;
        @(posedge clk); #1;
        fork
            run_aw(0, n0, gap, a0);
            run_aw(1, n1, gap, a1);
            run_w(0, n0, gap, w0);
            run_w(1, n1, gap, w1);
            begin
                if (fill) begin
                    repeat (400) @(negedge clk);
                    chk("full_blocks_17th", 64'(aw_cnt - aw_base), 64'(DEPTH));
                    chk("full_outstanding", 64'(outstanding), 64'(DEPTH));
                    b_budget = 1;
                    repeat (60) @(negedge clk);
                    chk("b_frees_17th", 64'(aw_cnt - aw_base), 64'(DEPTH + 1));
                    b_budget = 1000000;
                end
            end
        join
        t = 0;
        while ((w_order.size() > 0 || done_q.size() > 0 || exp_b.size() > 0 || m_bvalid || model_out != 0)
               && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) fail("drain");
        chk("phase_aw_count", 64'(aw_cnt - aw_base), 64'(n0 + n1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, beats;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awlen[i] = '0; s_awvalid[i] = 1'b1;
            s_wdata[i] = '1; s_wlast[i] = 1'b1; s_wvalid[i] = 1'b1; s_bready[i] = 1'b1;
        end
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_handshakes", 64'({bus.S0_AWREADY, bus.S1_AWREADY, bus.S0_WREADY, bus.S1_WREADY,
                                     bus.S0_BVALID, bus.S1_BVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                                     bus.M_AXI_BREADY}), 0);
        chk("reset_outstanding", 64'(outstanding), 0);
        chk("wstrb_ones", 64'(bus.M_AXI_WSTRB == {(DW/8){1'b1}}), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin s_awvalid[i] = 1'b0; s_wvalid[i] = 1'b0; end
        sys_reset = 1'b0;
        mon_en    = 1'b1;

        // Tie-break alternation and one-cycle request latency.
        ram_fast = 1'b1;
        run_phase(4, 4, 0, -1, 0, 0, 0, 0, 1'b0);
        chk("alt_count", 64'(aw_log.size()), 8);
        for (int k = 0; k < 8 && k < aw_log.size(); k++) chk("alt_grant", 64'(aw_log[k]), 64'(k % 2));
        chk("aw_latency", 64'(first_m_cyc - first_req_cyc), 1);

        // S1 AW first, S0 data offered early must be held.
        run_phase(1, 1, 0, 3, 4, 0, 0, 10, 1'b0);
        chk("hold_order_n", 64'(aw_log.size()), 2);
        if (aw_log.size() == 2) begin
            chk("hold_first_s1", 64'(aw_log[0]), 1);
            chk("hold_then_s0", 64'(aw_log[1]), 0);
        end

        // Random traffic with random backpressure.
        ram_fast = 1'b0;
        run_phase(20, 20, 3, -1, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 8), $urandom_range(0, 8), 1'b0);

        // Order FIFO full stalls grants until one B returns.
        ram_fast = 1'b1;
        run_phase(9, 8, 0, -1, 0, 0, 0, 0, 1'b1);

        // Asynchronous reset in the middle of an 8-beat burst.
        mon_en   = 1'b0;
        b_budget = 0;
        @(posedge clk); #1;
        s_awaddr[0] = 64'h1000; s_awlen[0] = 8'd7; s_awvalid[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_awready[0] && t < 100);
        chk("mid_aw_accepted", 64'(s_awready[0]), 1);
        @(posedge clk); #1;
        s_awvalid[0] = 1'b0;
        s_awaddr[1] = 64'h8000_0000_0000_2000; s_awlen[1] = 8'd0; s_awvalid[1] = 1'b1;
        s_wdata[0] = '1; s_wlast[0] = 1'b0; s_wvalid[0] = 1'b1;
        beats = 0; t = 0;
        while (beats < 2 && t < 100) begin @(negedge clk); t++; if (s_wready[0]) beats++; end
        chk("mid_beats", 64'(beats), 2);
        @(posedge clk); #2;
        chk("mid_burst_active", 64'(bus.M_AXI_WVALID), 1);
        sys_reset = 1'b1;
        #1;
        chk("async_reset_handshakes", 64'({bus.S0_AWREADY, bus.S1_AWREADY, bus.S0_WREADY, bus.S1_WREADY,
                                           bus.S0_BVALID, bus.S1_BVALID, bus.M_AXI_AWVALID,
                                           bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 0);
        chk("async_reset_outstanding", 64'(outstanding), 0);
        repeat (3) @(posedge clk);
        #1;
        sys_reset    = 1'b0;
        s_wvalid[0]  = 1'b0;
        s_awaddr[0]  = 64'h3000;
        s_awvalid[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_awready[0] && !s_awready[1] && t < 100);
        chk("post_reset_grant_s0", 64'(s_awready[0]), 1);
        chk("post_reset_not_s1", 64'(s_awready[1]), 0);
        @(posedge clk); #1;
        s_awvalid[0] = 1'b0;
        s_awvalid[1] = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
